instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the control decoder. Holds the PC, issues one-at-a-time

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and issues single-outstanding word reads to
// instruction memory. It buffers the returned words in a small FIFO and
// presents the head entry to decode. A redirect flushes in-flight and
// buffered instructions.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [5:0]        id_opcode,
  output logic [5:0]        id_fn_code,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [ADDR_W-1:0] id_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FLD_W = 27;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inflight_q, pc_inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [FLD_W-1:0]  fld_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q  [FIFO_DEPTH];

  logic              req_fire;
  logic              push;
  logic              pop;
  logic [FLD_W-1:0]  resp_fields;
  logic [FLD_W-1:0]  head_fields;
  logic              unused_shamt;

  // Only the decode-visible fields are buffered; the shift-amount field is dropped.
  assign resp_fields  = {imem_resp_data[31:11], imem_resp_data[5:0]};
  assign unused_shamt = ^imem_resp_data[10:6];

  // Request/handshake qualification; a redirect cancels any request this cycle.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && (state_q == S_REQ) &&
                     (count_q < CNT_W'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = !redirect_valid && (state_q == S_WAIT) && imem_resp_valid;
    id_valid       = (count_q != '0);
    pop            = !redirect_valid && id_valid && id_ready;
  end

  // Decode outputs straight from the FIFO head, zeroed when empty.
  always_comb begin
    head_fields = id_valid ? fld_mem_q[rd_ptr_q] : '0;
    id_pc       = id_valid ? pc_mem_q[rd_ptr_q]  : '0;
    id_opcode   = head_fields[26:21];
    id_rs       = head_fields[20:16];
    id_rt       = head_fields[15:11];
    id_rd       = head_fields[10:6];
    id_fn_code  = head_fields[5:0];
  end

  // Next-state: fetch FSM, PC advance, FIFO pointers and occupancy.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          pc_inflight_d = pc_q;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = S_WAIT;
        end
      end
      S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
      S_DRAIN: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // Redirect wins: flush, reload PC, and owe a drain if a response is still pending.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_resp_valid) state_d = S_DRAIN;
      else                                                              state_d = S_REQ;
    end
  end

  // Control registers; reset drains any response owed to a pre-reset request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pc_inflight_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_resp_valid) state_q <= S_DRAIN;
      else                                                              state_q <= S_REQ;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fld_mem_q[wr_ptr_q] <= resp_fields;
      pc_mem_q[wr_ptr_q]  <= pc_inflight_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus with scoreboard queues
// checked by a negedge monitor. A second instance covers the wrapping reset PC.
module tb_instr_fetch_unit;

  localparam logic [31:0] FIXED_W = 32'h0123_4820;
  localparam logic [31:0] W100    = 32'h8C43_0004;
  localparam logic [31:0] W104    = 32'h0085_3022;
  localparam logic [31:0] W200    = 32'hAFBF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } id_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [5:0]  id_opcode, id_fn_code;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_pc;

  // wrap-PC instance
  logic        r2_valid, r2_ready, r2_resp_valid;
  logic [31:0] r2_addr;
  logic        id2_valid;
  logic [5:0]  id2_opcode, id2_fn_code;
  logic [4:0]  id2_rs, id2_rt, id2_rd;
  logic [31:0] id2_pc;

  // memory model controls
  logic        auto_mode, fixed_en;
  logic        a_v, m_v, pend, pend2;
  logic [31:0] a_d, m_d, pend_addr;

  assign imem_resp_valid = auto_mode ? a_v : m_v;
  assign imem_resp_data  = auto_mode ? a_d : m_d;

  logic [31:0] exp_req[$];
  id_exp_t     exp_id[$];
  logic [31:0] exp_req2[$];
  logic [31:0] exp_pc2[$];

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  int req2_seen = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_fn_code(id_fn_code),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_pc(id_pc)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(r2_valid), .imem_req_ready(r2_ready),
    .imem_req_addr(r2_addr),
    .imem_resp_valid(r2_resp_valid), .imem_resp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id2_valid), .id_ready(1'b1),
    .id_opcode(id2_opcode), .id_fn_code(id2_fn_code),
    .id_rs(id2_rs), .id_rt(id2_rt), .id_rd(id2_rd), .id_pc(id2_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2] ^ 6'h3F, a[6:2], ~a[6:2], a[6:2] + 5'd1, 5'h00, a[7:2]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s actual=expired expected=event", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n = 0;
    while (req_seen < target && n < budget) begin cyc(); n++; end
    if (req_seen < target) timeout("req");
  endtask

  task automatic wait_ids(input int budget);
    int n = 0;
    while (exp_id.size() != 0 && n < budget) begin cyc(); n++; end
    if (exp_id.size() != 0) timeout("id");
  endtask

  // Memory responders: 1-cycle latency after each accepted request.
  initial begin
    a_v = 1'b0; a_d = '0; pend = 1'b0; pend_addr = '0;
    r2_resp_valid = 1'b0; pend2 = 1'b0;
    forever begin
      @(negedge clk);
      a_v           = auto_mode && pend;
      a_d           = fixed_en ? FIXED_W : mem_word(pend_addr);
      pend          = auto_mode && !rst && imem_req_valid && imem_req_ready;
      pend_addr     = imem_req_addr;
      r2_resp_valid = pend2;
      pend2         = !rst && r2_valid && r2_ready;
    end
  end

  // Monitor: pops the scoreboard on every observed handshake.
  initial begin
    logic [31:0] e;
    id_exp_t     ie;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        req_seen++;
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=%h expected=none", imem_req_addr);
        end else begin
          e = exp_req.pop_front();
          check("req_addr", 64'(imem_req_addr), 64'(e));
        end
      end
      if (!rst && id_valid && id_ready) begin
        if (exp_id.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_id actual=%h expected=none", id_pc);
        end else begin
          ie = exp_id.pop_front();
          check("id_pc", 64'(id_pc), 64'(ie.pc));
          check("id_fields", 64'({id_opcode, id_rs, id_rt, id_rd, id_fn_code}),
                64'({ie.word[31:26], ie.word[25:21], ie.word[20:16], ie.word[15:11], ie.word[5:0]}));
        end
      end
      if (!rst && r2_valid && r2_ready) begin
        req2_seen++;
        if (exp_req2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req2 actual=%h expected=none", r2_addr);
        end else begin
          e = exp_req2.pop_front();
          check("req2_addr", 64'(r2_addr), 64'(e));
        end
      end
      if (!rst && id2_valid && exp_pc2.size() != 0) begin
        e = exp_pc2.pop_front();
        check("id2_pc", 64'(id2_pc), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    id_ready = 1'b0; r2_ready = 1'b0; auto_mode = 1'b0; fixed_en = 1'b0;
    m_v = 1'b0; m_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_id_valid", 64'(id_valid), 64'(0));
    check("rst_id_fields", 64'({id_opcode, id_rs, id_rt, id_rd, id_fn_code, id_pc}), 64'(0));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'(1));
    check("first_req_addr", 64'(imem_req_addr), 64'h0);
    check("wrap_reset_addr", 64'(r2_addr), 64'hFFFF_FFFC);

    // sequential fetch, 1-cycle memory, decode always ready
    cyc();
    auto_mode = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'(4 * i));
      exp_id.push_back('{pc: 32'(4 * i), word: mem_word(32'(4 * i))});
    end
    base = req_seen;
    imem_req_ready = 1'b1;
    wait_reqs(base + 4, 60);
    imem_req_ready = 1'b0;
    wait_ids(20);

    // decode stalled: FIFO fills to depth then requests stop
    fixed_en = 1'b1; id_ready = 1'b0;
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h14);
    base = req_seen;
    imem_req_ready = 1'b1;
    wait_reqs(base + 2, 40);
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_req_valid", 64'(imem_req_valid), 64'(0));
      check("stall_fn_code", 64'(id_fn_code), 64'h20);
      check("stall_rd", 64'(id_rd), 64'd9);
      check("stall_pc", 64'(id_pc), 64'h10);
    end
    check("stall_req_count", 64'(req_seen - base), 64'd2);
    cyc();
    imem_req_ready = 1'b0;
    exp_id.push_back('{pc: 32'h10, word: FIXED_W});
    exp_id.push_back('{pc: 32'h14, word: FIXED_W});
    id_ready = 1'b1;
    wait_ids(20);
    fixed_en = 1'b0;

    // redirect while waiting on memory
    auto_mode = 1'b0; id_ready = 1'b0;
    cyc();
    exp_req.push_back(32'h18);
    base = req_seen;
    imem_req_ready = 1'b1;
    wait_reqs(base + 1, 10);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("redir_wait_req_valid", 64'(imem_req_valid), 64'(0));
    cyc();
    redirect_valid = 1'b0; m_v = 1'b1; m_d = 32'hDEAD_BEEF;
    @(negedge clk);
    check("drain_req_valid", 64'(imem_req_valid), 64'(0));
    check("drain_id_valid", 64'(id_valid), 64'(0));
    cyc();
    m_v = 1'b0;
    exp_req.push_back(32'h100);
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("post_drain_id_valid", 64'(id_valid), 64'(0));
    cyc();
    imem_req_ready = 1'b0; m_v = 1'b1; m_d = W100;
    exp_id.push_back('{pc: 32'h100, word: W100});
    @(negedge clk);
    check("redir_wait_id_valid", 64'(id_valid), 64'(0));
    cyc();
    m_v = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("redir_id_valid", 64'(id_valid), 64'(1));
    cyc();
    id_ready = 1'b0;

    // redirect in the same cycle as a response and a pop
    exp_req.push_back(32'h104);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; m_v = 1'b1; m_d = W104;
    exp_id.push_back('{pc: 32'h104, word: W104});
    cyc();
    m_v = 1'b0;
    exp_req.push_back(32'h108);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; m_v = 1'b1; m_d = 32'hBAD0_0BAD; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("redir_resp_req_valid", 64'(imem_req_valid), 64'(0));
    cyc();
    redirect_valid = 1'b0; m_v = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    check("flush_id_valid", 64'(id_valid), 64'(0));
    check("flush_req_valid", 64'(imem_req_valid), 64'(1));
    check("flush_req_addr", 64'(imem_req_addr), 64'h200);
    cyc();
    exp_req.push_back(32'h200);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; m_v = 1'b1; m_d = W200;
    exp_id.push_back('{pc: 32'h200, word: W200});
    cyc();
    m_v = 1'b0; id_ready = 1'b1;
    wait_ids(5);
    id_ready = 1'b0;

    // reset PC at the top of the address space wraps to zero
    exp_req2.push_back(32'hFFFF_FFFC);
    exp_req2.push_back(32'h0);
    exp_pc2.push_back(32'hFFFF_FFFC);
    exp_pc2.push_back(32'h0);
    base = req2_seen;
    r2_ready = 1'b1;
    for (int n = 0; n < 20 && req2_seen < base + 2; n++) cyc();
    r2_ready = 1'b0;
    check("wrap_req_count", 64'(req2_seen - base), 64'd2);
    repeat (4) cyc();
    check("wrap_id_left", 64'(exp_pc2.size()), 64'd0);

    // memory not ready: request held stable
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_req_valid", 64'(imem_req_valid), 64'(1));
      check("hold_req_addr", 64'(imem_req_addr), 64'h204);
      cyc();
    end
    auto_mode = 1'b1; id_ready = 1'b1;
    exp_req.push_back(32'h204);
    exp_id.push_back('{pc: 32'h204, word: mem_word(32'h204)});
    base = req_seen;
    imem_req_ready = 1'b1;
    wait_reqs(base + 1, 10);
    imem_req_ready = 1'b0;
    wait_ids(10);

    // reset with a request outstanding: late response must be dropped
    auto_mode = 1'b0; id_ready = 1'b0;
    exp_req.push_back(32'h208);
    base = req_seen;
    imem_req_ready = 1'b1;
    wait_reqs(base + 1, 10);
    imem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_req_valid", 64'(imem_req_valid), 64'(0));
    cyc();
    rst = 1'b0; m_v = 1'b1; m_d = 32'hFEED_F00D;
    @(negedge clk);
    check("midrst_drain_req_valid", 64'(imem_req_valid), 64'(0));
    check("midrst_id_valid", 64'(id_valid), 64'(0));
    cyc();
    m_v = 1'b0;
    @(negedge clk);
    check("midrst_req_valid_after", 64'(imem_req_valid), 64'(1));
    check("midrst_req_addr", 64'(imem_req_addr), 64'h0);
    check("midrst_id_valid_after", 64'(id_valid), 64'(0));

    check("exp_req_left", 64'(exp_req.size()), 64'd0);
    check("exp_id_left", 64'(exp_id.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
